// File: rtl/pred_pkg.sv
// Shared predictor types: 2-bit saturating counter, its named states, inc/dec helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: ctr2_t, CTR_* constants, pht_state_t, sat_inc(), sat_dec().
package pred_pkg;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT  = 2'd0;  // strongly not-taken
  localparam ctr2_t CTR_WNT  = 2'd1;  // weakly not-taken
  localparam ctr2_t CTR_WT   = 2'd2;  // weakly taken
  localparam ctr2_t CTR_ST   = 2'd3;  // strongly taken
  localparam ctr2_t CTR_INIT = CTR_WNT;

  typedef enum logic {
    PHT_INIT = 1'b0,
    PHT_RUN  = 1'b1
  } pht_state_t;

  function automatic ctr2_t sat_inc(input ctr2_t c);
    return (c == CTR_ST) ? CTR_ST : ctr2_t'(c + 2'd1);
  endfunction

  function automatic ctr2_t sat_dec(input ctr2_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr2_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/pht_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Latency: read data appears 1 cycle after re; write lands at the clock edge.
// Backpressure: none; a read and a write may occur every cycle (read returns old data on collision).
// Ports: clk, rst (clears only the read register), we/waddr/wdata, re/raddr, rdata.
module pht_ram #(
  parameter int AW = 14,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Both ports sample mem at the same edge, so a same-address read sees the old word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pht_counter_table.sv
// Pattern history table of 2-bit saturating counters; self-initialises to weakly-not-taken after reset.
// Latency: prediction valid 1 cycle after an accepted request; update written at the accepting edge.
// Backpressure: none once ready=1; all requests are ignored while ready=0 (init sweep).
// Ports: clk, rst, ready; pred_valid/pred_index -> pred_valid_o/pred_taken/pred_ctr;
//        upd_valid/upd_index/upd_ctr/upd_taken.
// Build option: PHT_WRITE_BYPASS_EN makes a same-index same-cycle prediction return the new counter.
module pht_counter_table
  import pred_pkg::*;
#(
  parameter int HASH_width = 14,
  parameter int CTR_width  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  pred_valid,
  input  logic [HASH_width-1:0] pred_index,
  output logic                  pred_valid_o,
  output logic                  pred_taken,
  output ctr2_t                 pred_ctr,
  input  logic                  upd_valid,
  input  logic [HASH_width-1:0] upd_index,
  input  ctr2_t                 upd_ctr,
  input  logic                  upd_taken
);

  pht_state_t            state_q, state_d;
  logic [HASH_width-1:0] ptr_q;
  logic                  sweep_we;
  logic                  pred_acc, upd_acc;
  ctr2_t                 upd_new;
  logic                  ram_we;
  logic [HASH_width-1:0] ram_waddr;
  logic [CTR_width-1:0]  ram_wdata;
  logic [CTR_width-1:0]  ram_rdata;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= PHT_INIT;
    else     state_q <= state_d;
  end

  // Next state: INIT leaves once the last entry is written; RUN only exits via rst.
  always_comb begin
    state_d = state_q;
    if (state_q == PHT_INIT && ptr_q == '1) state_d = PHT_RUN;
  end

  // Outputs of the FSM
  always_comb begin
    ready    = 1'b0;
    sweep_we = 1'b0;
    case (state_q)
      PHT_INIT: sweep_we = 1'b1;
      PHT_RUN:  ready    = 1'b1;
      default:  ;
    endcase
  end

  // Sweep pointer wraps to 0 after the last entry, harmlessly, since it is only used in INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           ptr_q <= '0;
    else if (sweep_we) ptr_q <= ptr_q + 1'b1;
  end

  assign pred_acc = ready & pred_valid;
  assign upd_acc  = ready & upd_valid;

  // Commit returns the counter seen at prediction time, so no read-modify-write is needed.
  assign upd_new = upd_taken ? sat_inc(upd_ctr) : sat_dec(upd_ctr);

  assign ram_we    = sweep_we | upd_acc;
  assign ram_waddr = sweep_we ? ptr_q : upd_index;
  assign ram_wdata = sweep_we ? CTR_INIT : upd_new;

  pht_ram #(
    .AW (HASH_width),
    .DW (CTR_width)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (pred_acc),
    .raddr (pred_index),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pred_valid_o <= 1'b0;
    else     pred_valid_o <= pred_acc;
  end

`ifdef PHT_WRITE_BYPASS_EN
  // The RAM returns the old word on a same-address collision; remember the new one and override.
  logic  byp_hit_q;
  ctr2_t byp_ctr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byp_hit_q <= 1'b0;
      byp_ctr_q <= CTR_SNT;
    end else begin
      byp_hit_q <= pred_acc & upd_acc & (pred_index == upd_index);
      byp_ctr_q <= upd_new;
    end
  end

  assign pred_ctr = byp_hit_q ? byp_ctr_q : ram_rdata;
`else
  assign pred_ctr = ram_rdata;
`endif

  assign pred_taken = pred_ctr[1];

endmodule

// File: tb/tb_pht_counter_table.sv
module tb_pht_counter_table;

  localparam int HW = 4;
  localparam int N  = 1 << HW;
`ifdef PHT_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready;
  logic          pred_valid = 1'b0;
  logic [HW-1:0] pred_index = '0;
  logic          pred_valid_o;
  logic          pred_taken;
  logic [1:0]    pred_ctr;
  logic          upd_valid = 1'b0;
  logic [HW-1:0] upd_index = '0;
  logic [1:0]    upd_ctr = '0;
  logic          upd_taken = 1'b0;

  pht_counter_table #(.HASH_width(HW), .CTR_width(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .pred_valid   (pred_valid),
    .pred_index   (pred_index),
    .pred_valid_o (pred_valid_o),
    .pred_taken   (pred_taken),
    .pred_ctr     (pred_ctr),
    .upd_valid    (upd_valid),
    .upd_index    (upd_index),
    .upd_ctr      (upd_ctr),
    .upd_taken    (upd_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int ctr;
  } exp_t;

  exp_t q[$];
  int   model[N];
  bit   tb_ready = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: a 2-bit counter moves one step toward the outcome, clamped to 0..3.
  function automatic int next_ctr(input int c, input bit t);
    int v;
    v = t ? c + 1 : c - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented prediction must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && pred_valid_o) begin
      if (q.size() == 0) begin
        chk("unexpected_pred_valid_o", 1, 0);
      end else begin
        e = q.pop_front();
        chk($sformatf("pred_ctr[idx%0d]", e.idx), int'(pred_ctr), e.ctr);
        chk($sformatf("pred_taken[idx%0d]", e.idx), int'(pred_taken), (e.ctr >= 2) ? 1 : 0);
      end
    end
  end

  task automatic idle_inputs();
    pred_valid = 1'b0;
    upd_valid  = 1'b0;
  endtask

  // One clock of stimulus; expectation pushed, model updated, then the edge is taken.
  task automatic cyc(input bit pv, input int pi, input bit uv, input int ui,
                     input int uc, input bit ut);
    exp_t e;
    pred_valid = pv;
    pred_index = HW'(pi);
    upd_valid  = uv;
    upd_index  = HW'(ui);
    upd_ctr    = 2'(uc);
    upd_taken  = ut;
    if (tb_ready && pv) begin
      e.idx = pi;
      e.ctr = (BYP && uv && ui == pi) ? next_ctr(uc, ut) : model[pi];
      q.push_back(e);
    end
    if (tb_ready && uv) model[ui] = next_ctr(uc, ut);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Called just after rst deasserts; checks ready timing, optionally hammering the ports.
  task automatic sweep(input bit busy);
    for (int i = 1; i <= N; i++) begin
      pred_valid = busy;
      pred_index = HW'($urandom_range(0, N - 1));
      upd_valid  = busy;
      upd_index  = HW'($urandom_range(0, N - 1));
      upd_ctr    = 2'($urandom_range(0, 3));
      upd_taken  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk($sformatf("ready_sweep_c%0d", i), int'(ready), (i == N) ? 1 : 0);
      chk("pred_valid_o_in_init", int'(pred_valid_o), 0);
    end
    idle_inputs();
    tb_ready = 1'b1;
    for (int i = 0; i < N; i++) model[i] = 1;
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) cyc(1, i, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_pred_valid_o", int'(pred_valid_o), 0);
    chk("rst_pred_taken", int'(pred_taken), 0);
    chk("rst_pred_ctr", int'(pred_ctr), 0);

    // Sweep with ports held busy; nothing may leak through, table must be all weakly-not-taken.
    rst = 1'b0;
    sweep(1'b1);
    read_all();

    // Basic update then predict
    cyc(0, 0, 1, 5, 1, 1);
    cyc(1, 5, 0, 0, 0, 0);
    // Saturation both ends, plus a plain decrement
    cyc(0, 0, 1, 3, 3, 1);
    cyc(1, 3, 0, 0, 0, 0);
    cyc(0, 0, 1, 4, 0, 0);
    cyc(1, 4, 0, 0, 0, 0);
    cyc(0, 0, 1, 9, 2, 0);
    cyc(1, 9, 0, 0, 0, 0);
    // Same-index collision, then a re-read, then different-index concurrency
    cyc(1, 7, 1, 7, 1, 1);
    cyc(1, 7, 0, 0, 0, 0);
    cyc(1, 8, 1, 10, 1, 1);
    cyc(1, 10, 0, 0, 0, 0);
    // Back-to-back updates: last write wins
    cyc(0, 0, 1, 11, 0, 1);
    cyc(0, 0, 1, 11, 3, 0);
    cyc(1, 11, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
          1'($urandom_range(0, 1)), $urandom_range(0, N - 1),
          $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("queue_drained_run", q.size(), 0);

    // Reset with a prediction in flight: it must vanish at once
    cyc(1, 2, 0, 0, 0, 0);
    rst = 1'b1;
    tb_ready = 1'b0;
    #1;
    chk("inflight_drop_valid", int'(pred_valid_o), 0);
    chk("inflight_drop_ctr", int'(pred_ctr), 0);
    chk("inflight_drop_ready", int'(ready), 0);
    q.delete();
    @(posedge clk); #1;

    // Reset mid-sweep at cycle 6, then a full restart
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midsweep_ready", int'(ready), 0);
    chk("midsweep_valid", int'(pred_valid_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep(1'b0);
    read_all();

    cyc(0, 0, 0, 0, 0, 0);
    chk("queue_drained_end", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
